conf_int_div_seq: RTL and testbench

CONF_INT_DIV_SEQ -- requirements
Module: conf_int_div_seq

---
 rtl/conf_int_div_pkg.sv | 14 +
 rtl/conf_int_div_step.sv | 25 ++
 rtl/conf_int_div_seq.sv | 144 ++++++++++++++
 tb/tb_conf_int_div_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and default operand/datapath widths.
package conf_int_div_pkg;

   localparam int DEF_OP_BITWIDTH        = 16;
   localparam int DEF_DATA_PATH_BITWIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/conf_int_div_step.sv
// One restoring-division step: shift the partial remainder left bringing in the
// next dividend bit, trial-subtract the divisor, keep the difference or restore.
module conf_int_div_step #(
   parameter int W = 16
) (
   input  logic [W:0]   rem_i,
   input  logic         dvd_msb_i,
   input  logic [W-1:0] dvs_i,
   output logic [W:0]   rem_o,
   output logic         qbit_o
);

   logic [W:0] shifted;
   logic [W:0] diff;

   // rem_i[W] is the bit shifted out of the (W+1)-bit window; if ever set, the
   // true shifted value exceeds any divisor, and the modular difference is exact.
   always_comb begin
      shifted = {rem_i[W-1:0], dvd_msb_i};
      diff    = shifted - {1'b0, dvs_i};
      qbit_o  = rem_i[W] | (shifted >= {1'b0, dvs_i});
      rem_o   = qbit_o ? diff : shifted;
   end

endmodule

// File: rtl/conf_int_div_seq.sv
// Sequential unsigned W-bit restoring divider with optional approximate mode
// (low operand bits zeroed) and valid/ready handshakes on both sides.
module conf_int_div_seq
   import conf_int_div_pkg::*;
#(
   parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
   parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
   input  logic                          clk,
   input  logic                          racc,
   input  logic                          apx,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] q,
   output logic [DATA_PATH_BITWIDTH-1:0] r,
   output logic                          div_by_zero
);

   localparam int W        = DATA_PATH_BITWIDTH;
   localparam int CNT_W    = $clog2(W + 1);
   localparam int LSB_BITS = W - OP_BITWIDTH;

   localparam logic [W-1:0]     APX_MASK = {W{1'b1}} << LSB_BITS;
   localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(W - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W:0]       rem_q, rem_d;
   logic [W-1:0]     dq_q, dq_d;
   logic [W-1:0]     dvs_q, dvs_d;
   logic [W-1:0]     q_q, q_d;
   logic [W-1:0]     r_q, r_d;
   logic             dbz_q, dbz_d;

   logic [W-1:0]     a_eff;
   logic [W-1:0]     b_eff;
   logic [W:0]       step_rem;
   logic             step_qbit;
   logic [W-1:0]     dq_shift;

   assign a_eff = apx ? (a & APX_MASK) : a;
   assign b_eff = apx ? (b & APX_MASK) : b;

   conf_int_div_step #(
      .W (W)
   ) u_step (
      .rem_i     (rem_q),
      .dvd_msb_i (dq_q[W-1]),
      .dvs_i     (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   // dq_q starts as the dividend; each step consumes its MSB and appends a
   // quotient bit at the LSB, so after W steps it holds the full quotient.
   assign dq_shift = (dq_q << 1) | W'(step_qbit);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dq_d    = dq_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (b_eff == '0) begin
                  state_d = ST_DONE;
                  q_d     = '1;
                  r_d     = a_eff;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  rem_d   = '0;
                  dq_d    = a_eff;
                  dvs_d   = b_eff;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
               end
            end
         end

         ST_CALC: begin
            rem_d = step_rem;
            dq_d  = dq_shift;
            if (cnt_q == LAST_IT) begin
               state_d = ST_DONE;
               q_d     = dq_shift;
               r_d     = step_rem[W-1:0];
               dbz_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge racc) begin
      if (!racc) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dq_q    <= dq_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign q           = q_q;
   assign r           = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_conf_int_div_seq.sv
// Self-checking bench for conf_int_div_seq (W=16, OP_BITWIDTH=8): a transaction-level
// reference model checked every cycle, plus directed vectors with literal results.
module tb_conf_int_div_seq;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          racc;
   logic          apx;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  q;
   logic [W-1:0]  r;
   logic          div_by_zero;

   int total = 0;
   int bad   = 0;

   conf_int_div_seq #(
      .OP_BITWIDTH        (8),
      .DATA_PATH_BITWIDTH (W)
   ) dut (
      .clk         (clk),
      .racc        (racc),
      .apx         (apx),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: phase 0=idle, 1=busy, 2=result held.
   int          m_phase = 0;
   int          m_cnt   = 0;
   logic [W-1:0] m_q    = '0;
   logic [W-1:0] m_r    = '0;
   logic        m_dbz   = 1'b0;
   bit          m_zero  = 1'b1;

   always @(posedge clk or negedge racc) begin
      logic [W-1:0] ae;
      logic [W-1:0] be;
      if (!racc) begin
         m_phase <= 0;
         m_cnt   <= 0;
         m_q     <= '0;
         m_r     <= '0;
         m_dbz   <= 1'b0;
         m_zero  <= 1'b1;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               ae = apx ? (a & 16'hFF00) : a;
               be = apx ? (b & 16'hFF00) : b;
               m_zero <= 1'b0;
               if (be == 0) begin
                  m_phase <= 2;
                  m_q     <= 16'hFFFF;
                  m_r     <= ae;
                  m_dbz   <= 1'b1;
               end else begin
                  m_phase <= 1;
                  m_cnt   <= W;
                  m_q     <= ae / be;
                  m_r     <= ae % be;
                  m_dbz   <= 1'b0;
               end
            end
            1: begin
               if (m_cnt == 1) m_phase <= 2;
               m_cnt <= m_cnt - 1;
            end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      check("mdl_in_ready", in_ready, m_phase == 0);
      check("mdl_out_valid", out_valid, m_phase == 2);
      if (m_phase == 2 || m_zero) begin
         check("mdl_q", q, m_q);
         check("mdl_r", r, m_r);
         check("mdl_dbz", div_by_zero, m_dbz);
      end
   end

   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ap);
      a        = av;
      b        = bv;
      apx      = ap;
      in_valid = 1'b1;
   endtask

   // Called on the first negedge after the acceptance edge.
   task automatic wait_done(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ed, input int elat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, elat);
      check({tag, "_q"}, q, eq);
      check({tag, "_r"}, r, er);
      check({tag, "_dbz"}, div_by_zero, ed);
   endtask

   task automatic finish_op(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ed, input int elat);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(tag, eq, er, ed, elat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_back_idle"}, in_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ap, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input int elat);
      @(negedge clk);
      start_op(av, bv, ap);
      finish_op(tag, eq, er, ed, elat);
   endtask

   initial begin
      racc      = 1'b0;
      apx       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_q", q, 0);
      check("rst_r", r, 0);
      check("rst_dbz", div_by_zero, 0);

      // Operands presented together with reset release.
      racc = 1'b1;
      start_op(16'd100, 16'd7, 1'b0);
      finish_op("d100_7", 16'd14, 16'd2, 1'b0, 16);

      run_op("ffff_1", 16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 16);
      run_op("d5_9", 16'd5, 16'd9, 1'b0, 16'd0, 16'd5, 1'b0, 16);
      run_op("dz", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 0);
      run_op("exact", 16'h1234, 16'h0311, 1'b0, 16'd5, 16'h02DF, 1'b0, 16);
      run_op("apx", 16'h1234, 16'h0311, 1'b1, 16'd6, 16'd0, 1'b0, 16);
      run_op("apx_dz", 16'h1234, 16'h0011, 1'b1, 16'hFFFF, 16'h1200, 1'b1, 0);

      // Backpressure in DONE with new operands already waiting.
      @(negedge clk);
      start_op(16'hC350, 16'd123, 1'b0);
      @(negedge clk);
      a = 16'h00FF;
      b = 16'h0010;
      wait_done("hold", 16'd406, 16'd62, 1'b0, 16);
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
         check("hold_q", q, 16'd406);
         check("hold_r", r, 16'd62);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rel_in_ready", in_ready, 1);
      check("rel_out_valid", out_valid, 0);
      @(negedge clk);
      check("rel_accepted", in_ready, 0);
      in_valid = 1'b0;
      wait_done("after_hold", 16'd15, 16'd15, 1'b0, 16);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Abort in the middle of a calculation.
      @(negedge clk);
      start_op(16'd1000, 16'd33, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      racc = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_q", q, 0);
      check("abort_r", r, 0);
      check("abort_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      racc = 1'b1;
      start_op(16'd1000, 16'd33, 1'b0);
      finish_op("post_abort", 16'd30, 16'd10, 1'b0, 16);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
